// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: function-select codes and the B-invert bit.
package alu_pkg;

   // F[2] inverts B and injects the adder carry-in, turning add into subtract
   localparam int unsigned INV_B = 2;
   localparam int unsigned F_W   = 3;

   typedef enum logic [F_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_RSVD = 3'b011,
      OP_ANDN = 3'b100,
      OP_ORN  = 3'b101,
      OP_SUB  = 3'b110,
      OP_SLT  = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// N-bit adder/subtractor with carry-out and signed overflow.
//   A, B   : operands (B is the uninverted operand)
//   sub    : 1 -> A - B (invert B, carry-in 1), 0 -> A + B
//   S      : N-bit sum/difference
//   carry  : adder carry-out (for subtract, 1 = no borrow)
//   ovf    : signed overflow of the subtraction A - B
module alu_addsub #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         sub,
   output logic [N-1:0] S,
   output logic         carry,
   output logic         ovf
);

   logic [N-1:0] b_eff;
   logic [N:0]   full;

   // Sum computed one bit wider so the carry falls out of the top bit
   always_comb begin
      b_eff = sub ? ~B : B;
      full  = {1'b0, A} + {1'b0, b_eff} + (N+1)'(sub);
   end

   assign S     = full[N-1:0];
   assign carry = full[N];
   // Overflow of A - B: operand signs differ and result sign differs from A
   assign ovf   = (A[N-1] != B[N-1]) & (S[N-1] != A[N-1]);

endmodule

// File: rtl/alu.sv
// Parameterized N-bit ALU with registered outputs (1-cycle latency).
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset (Y=0, Cout=0, zf=1)
//   A, B   : operands
//   F      : function select, F[2] = invert B, F[1:0] = operation
//   Y      : registered result
//   Cout   : registered adder carry-out (valid for every F code)
//   zf     : registered zero flag of Y
module alu
   import alu_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   F,
   output logic [N-1:0] Y,
   output logic         Cout,
   output logic         zf
);

   logic         sub;
   logic [N-1:0] bb;
   logic [N-1:0] sum;
   logic         carry;
   logic         ovf;
   logic         lt;
   logic [N-1:0] y_next;

   assign sub = F[INV_B];
   assign bb  = sub ? ~B : B;

   alu_addsub #(.N(N)) u_addsub (
      .A     (A),
      .B     (B),
      .sub   (sub),
      .S     (sum),
      .carry (carry),
      .ovf   (ovf)
   );

   // Signed less-than: sign of A - B corrected for overflow
   assign lt = sum[N-1] ^ ovf;

   // Result mux
   always_comb begin
      y_next = '0;
      case (alu_op_e'(F))
         OP_AND,  OP_ANDN: y_next = A & bb;
         OP_OR,   OP_ORN:  y_next = A | bb;
         OP_ADD,  OP_SUB:  y_next = sum;
         OP_SLT:           y_next = N'(lt);
         OP_RSVD:          y_next = '0;
      endcase
   end

   // Output register
   always_ff @(posedge clk) begin
      if (reset) begin
         Y    <= '0;
         Cout <= 1'b0;
         zf   <= 1'b1;
      end else begin
         Y    <= y_next;
         Cout <= carry;
         zf   <= (y_next == '0);
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (N = 32): directed vector table plus
// hand-written reset, back-to-back and mid-stream reset sequences.
module tb_alu;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  f;
   logic [31:0] y;
   logic        cout;
   logic        zf;

   int checks = 0;
   int errors = 0;

   alu #(.N(32)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (a),
      .B     (b),
      .F     (f),
      .Y     (y),
      .Cout  (cout),
      .zf    (zf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [31:0] y;
      logic        cout;
      logic        zf;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   task automatic check_out(input string name, input logic [31:0] ey,
                            input logic ec, input logic ez);
      checks++;
      if (y !== ey) begin
         errors++;
         $display("FAIL %s Y: got %h expected %h", name, y, ey);
      end
      checks++;
      if (cout !== ec) begin
         errors++;
         $display("FAIL %s Cout: got %b expected %b", name, cout, ec);
      end
      checks++;
      if (zf !== ez) begin
         errors++;
         $display("FAIL %s zf: got %b expected %b", name, zf, ez);
      end
   endtask

   // Reference model written from the operation definitions
   function automatic logic [33:0] model(input logic [31:0] ma,
                                         input logic [31:0] mb,
                                         input logic [2:0]  mf);
      logic [31:0] r;
      logic [32:0] wide;
      logic        c;
      case (mf)
         3'b000:  r = ma & mb;
         3'b001:  r = ma | mb;
         3'b010:  r = ma + mb;
         3'b011:  r = 32'd0;
         3'b100:  r = ma & ~mb;
         3'b101:  r = ma | ~mb;
         3'b110:  r = ma - mb;
         default: r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
      endcase
      wide = {1'b0, ma} + {1'b0, mb};
      c = mf[2] ? (ma >= mb) : wide[32];
      return {r, c, (r == 32'd0)};
   endfunction

   task automatic drive(input logic [31:0] da, input logic [31:0] db,
                        input logic [2:0] df);
      @(negedge clk);
      a = da;
      b = db;
      f = df;
   endtask

   initial begin
      logic [33:0] e;
      logic [31:0] pa [8];
      logic [31:0] pb [8];

      vecs[0]  = '{32'd34,         32'd26,         3'b000, 32'd2,          1'b0, 1'b0};
      vecs[1]  = '{32'd14,         32'd2,          3'b001, 32'd14,         1'b0, 1'b0};
      vecs[2]  = '{32'd180,        32'd267,        3'b100, 32'd180,        1'b0, 1'b0};
      vecs[3]  = '{32'd1543,       32'd23,         3'b101, 32'hFFFF_FFEF,  1'b1, 1'b0};
      vecs[4]  = '{32'd1,          32'd2,          3'b010, 32'd3,          1'b0, 1'b0};
      vecs[5]  = '{32'd1543,       32'd23,         3'b110, 32'd1520,       1'b1, 1'b0};
      vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1'b1, 1'b1};
      vecs[7]  = '{32'd143,        32'd23,         3'b111, 32'd0,          1'b1, 1'b1};
      vecs[8]  = '{32'd1,          32'd223,        3'b111, 32'd1,          1'b0, 1'b0};
      vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          1'b1, 1'b0};
      vecs[10] = '{32'h8000_0000,  32'd1,          3'b111, 32'd1,          1'b1, 1'b0};
      vecs[11] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  3'b111, 32'd0,          1'b0, 1'b1};
      vecs[12] = '{32'd5,          32'd7,          3'b011, 32'd0,          1'b0, 1'b1};
      vecs[13] = '{32'hFFFF_FFF0,  32'h20,         3'b011, 32'd0,          1'b1, 1'b1};
      vecs[14] = '{32'd0,          32'd0,          3'b000, 32'd0,          1'b0, 1'b1};

      // Reset held two cycles with arbitrary operands applied
      reset = 1'b1;
      a = 32'h1234_5678;
      b = 32'h0000_0001;
      f = 3'b010;
      @(posedge clk); #1;
      check_out("reset_cycle1", 32'd0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_out("reset_cycle2", 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;

      // Directed vector table, one new operation every cycle
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].f);
         @(posedge clk); #1;
         check_out($sformatf("vec%0d", i), vecs[i].y, vecs[i].cout, vecs[i].zf);
      end

      // Back-to-back sweep across all eight codes, twice with fresh operands
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 8; k++) begin
            pa[k] = $urandom;
            pb[k] = (k == 3) ? pa[k] : $urandom;
         end
         for (int k = 0; k < 8; k++) begin
            drive(pa[k], pb[k], 3'(k));
            @(posedge clk); #1;
            e = model(pa[k], pb[k], 3'(k));
            check_out($sformatf("b2b_p%0d_f%0d", pass, k), e[33:2], e[1], e[0]);
         end
      end

      // Mid-stream reset: the operation sampled with reset high never appears
      drive(32'd100, 32'd7, 3'b110);
      @(posedge clk); #1;
      check_out("stream_pre", 32'd93, 1'b1, 1'b0);
      drive(32'hDEAD_BEEF, 32'h0000_00FF, 3'b001);
      reset = 1'b1;
      @(posedge clk); #1;
      check_out("stream_reset", 32'd0, 1'b0, 1'b1);
      drive(32'd40, 32'd2, 3'b010);
      reset = 1'b0;
      @(posedge clk); #1;
      check_out("stream_post", 32'd42, 1'b0, 1'b0);
      drive(32'd3, 32'd9, 3'b111);
      @(posedge clk); #1;
      check_out("stream_post2", 32'd1, 1'b0, 1'b0);

      // Outputs hold between edges
      @(negedge clk);
      a = 32'd0;
      b = 32'd0;
      f = 3'b000;
      #1;
      check_out("hold_between_edges", 32'd1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

Parameterized N-bit integer ALU with registered outputs. Computes AND, OR, add, subtract and signed set-less-than, with optional bitwise inversion of B, and returns the result, adder carry-out and a zero flag one clock after the operands are applied. Serves as the datapath execute unit of the processor core.

## Interface
- N, default 32: operand and result width, N >= 2.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  N  operand A.
- B  input  N  operand B.
- F  input  3  function select. F[2] = invert B; F[1:0] = operation.
- Y  output  N  registered result.
- Cout  output  1  registered carry-out of the internal adder.
- zf  output  1  registered zero flag, 1 when Y == 0.

## Operation
- Internal BB = F[2] ? ~B : B.
- Internal adder: {carry, S} = A + BB + F[2], computed at N+1 bits.
  - F[2] = 1 gives A - B in two's complement.
- F encodings:
  - 000: A & B.
  - 001: A | B.
  - 010: A + B.
  - 011: reserved; Y = 0.
  - 100: A & ~B.
  - 101: A | ~B.
  - 110: A - B.
  - 111: signed SLT. Y = {N-1 zeros, lt}, where lt = S[N-1] XOR ovf and ovf = (A[N-1] != B[N-1]) & (S[N-1] != A[N-1]).
- Cout is the adder carry for every F code, including logic ops and the reserved code. For subtract, Cout = 1 means no borrow (A >= B unsigned).
- zf = (Y_next == 0), evaluated on the value being registered.
- No overflow output. Wrap-around is modulo 2^N.

## Timing
- Every rising edge, with reset = 0: A, B and F are sampled and Y, Cout, zf are updated with the result. Latency is exactly 1 cycle.
- Full throughput: a new operation can be applied every cycle. There is no handshake and no stall.
- Reset = 1 at an edge forces Y = 0, Cout = 0, zf = 1. Reset has priority over any operation in flight, and that operation's result is discarded.
- The first post-reset result appears one edge after reset deasserts.
- Outputs are held stable between edges. There are no combinational input-to-output paths.
- X or undefined inputs are not scrubbed.

## Structure
- Shared package alu_pkg holds:
  - F code localparams or enum: AND, OR, ADD, RSVD, ANDN, ORN, SUB, SLT.
  - The INV_B bit index (2).
- One natural sub-module, alu_addsub, parameterized by N:
  - inputs A, B, sub.
  - outputs S, carry, ovf.
- Top level contains the B inversion mux, the result mux, zero detection and the output register.

## Test plan
- Reset: hold reset for 2 cycles with arbitrary inputs -> Y = 0, Cout = 0, zf = 1.
- Logic ops, N = 32, each result checked one cycle after apply:
  - A = 34, B = 26, F = 000 -> Y = 2, Cout = 0, zf = 0.
  - A = 14, B = 2, F = 001 -> Y = 14.
  - A = 180, B = 267, F = 100 -> Y = 180, Cout = 0.
  - A = 1543, B = 23, F = 101 -> Y = 0xFFFFFFEF, Cout = 1.
- Add and subtract:
  - A = 1, B = 2, F = 010 -> Y = 3, Cout = 0.
  - A = 1543, B = 23, F = 110 -> Y = 1520, Cout = 1.
  - A = 0xFFFFFFFF, B = 1, F = 010 -> Y = 0, Cout = 1, zf = 1.
- SLT:
  - A = 143, B = 23 -> Y = 0, zf = 1, Cout = 1.
  - A = 1, B = 223 -> Y = 1, Cout = 0.
  - A = 0xFFFFFFFF, B = 1 -> Y = 1.
  - A = 0x80000000, B = 1 (overflow case) -> Y = 1.
  - A = 0x7FFFFFFF, B = 0xFFFFFFFF -> Y = 0.
- Back-to-back and reserved code:
  - Change F every cycle across all 8 codes; each output must match the prior cycle's inputs.
  - F = 011 -> Y = 0, zf = 1, Cout equals the A + B carry.
- Reset mid-stream: assert reset while ops are streaming -> next outputs are the reset values; the in-flight result never appears.
